// File: rtl/not_word.sv
// not_word: combinational bitwise inverter plus a registered inverse with valid and all-zero flags
module not_word #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             en,
  output logic [WIDTH-1:0] not_a,
  output logic [WIDTH-1:0] not_a_q,
  output logic             valid_q,
  output logic             zero_q
);
  logic [WIDTH-1:0] not_a_d;
  logic             valid_d;
  logic             zero_d;
  assign not_a = ~a;
  // zero flag compares the operand to all ones so it never depends on the inverted bus
  always_comb begin
    not_a_d = en ? ~a : not_a_q;
    zero_d  = en ? (a == {WIDTH{1'b1}}) : zero_q;
    valid_d = en;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      not_a_q <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      not_a_q <= not_a_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_not_word.sv
// tb_not_word: vector table, directed reset/hold sequences and random sweeps against an arithmetic model
module tb_not_word;
  localparam int W = 32;
  localparam logic [W-1:0] ONES = 32'hFFFFFFFF;
  logic clk = 1'b0;
  logic rst_n;
  logic [W-1:0] a;
  logic en;
  logic [W-1:0] not_a, not_a_q;
  logic valid_q, zero_q;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] m_q;
  logic m_v, m_z;

  not_word #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .en(en),
    .not_a(not_a), .not_a_q(not_a_q), .valid_q(valid_q), .zero_q(zero_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: inverse as (all ones - a), updated from the inputs present at the edge
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) begin
      m_q = '0; m_v = 1'b0; m_z = 1'b0;
    end else begin
      m_v = en;
      if (en) begin
        m_q = ONES - a;
        m_z = (m_q == 0);
      end
    end
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".not_a_q"}, 64'(not_a_q), 64'(m_q));
    check({tag, ".valid_q"}, 64'(valid_q), 64'(m_v));
    check({tag, ".zero_q"}, 64'(zero_q), 64'(m_z));
  endtask

  initial begin
    vec_t tbl[6];
    tbl[0] = '{32'h00000000, 32'hFFFFFFFF};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000000};
    tbl[2] = '{32'hA5A5A5A5, 32'h5A5A5A5A};
    tbl[3] = '{32'h12345678, 32'hEDCBA987};
    tbl[4] = '{32'h00000001, 32'hFFFFFFFE};
    tbl[5] = '{32'h80000000, 32'h7FFFFFFF};
    rst_n = 1'b0; en = 1'b1; a = 32'h0;
    m_q = '0; m_v = 1'b0; m_z = 1'b0;
    cyc();
    check_regs("reset");
    for (int i = 0; i < 6; i++) begin
      a = tbl[i].a;
      #1;
      check($sformatf("tbl%0d.not_a", i), 64'(not_a), 64'(tbl[i].exp));
    end
    for (int i = 0; i < 1024; i++) begin
      a = $urandom;
      #1;
      check("sweep.not_a", 64'(not_a), 64'(ONES - a));
    end
    // reset then first capture after release
    rst_n = 1'b0; en = 1'b0; cyc();
    rst_n = 1'b1; en = 1'b1; a = 32'h0000FFFF; cyc();
    check("rel.not_a_q", 64'(not_a_q), 64'(32'hFFFF0000));
    check("rel.valid_q", 64'(valid_q), 64'd1);
    check("rel.zero_q", 64'(zero_q), 64'd0);
    // capture all ones then hold
    a = 32'hFFFFFFFF; cyc();
    check("ones.not_a_q", 64'(not_a_q), 64'd0);
    check("ones.zero_q", 64'(zero_q), 64'd1);
    check("ones.valid_q", 64'(valid_q), 64'd1);
    en = 1'b0; a = 32'h12345678; cyc();
    check("hold.not_a_q", 64'(not_a_q), 64'd0);
    check("hold.zero_q", 64'(zero_q), 64'd1);
    check("hold.valid_q", 64'(valid_q), 64'd0);
    check("hold.not_a", 64'(not_a), 64'(32'hEDCBA987));
    // capture with reset on the same edge, after a nonzero capture
    en = 1'b1; a = 32'h0000FFFF; cyc();
    check("pre.not_a_q", 64'(not_a_q), 64'(32'hFFFF0000));
    a = 32'h1; rst_n = 1'b0;
    #1;
    check("rstcap.not_a_pre", 64'(not_a), 64'(32'hFFFFFFFE));
    cyc();
    check("rstcap.not_a_q", 64'(not_a_q), 64'd0);
    check("rstcap.valid_q", 64'(valid_q), 64'd0);
    check("rstcap.zero_q", 64'(zero_q), 64'd0);
    check("rstcap.not_a", 64'(not_a), 64'(32'hFFFFFFFE));
    rst_n = 1'b1;
    // back-to-back captures
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; a = $urandom; cyc();
      check_regs("b2b");
    end
    // random registered traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 9) != 0);
      en = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = ONES;
        default: a = $urandom;
      endcase
      cyc();
      check_regs("rand");
      check("rand.not_a", 64'(not_a), 64'(ONES - a));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/not_word.md
NOT_WORD -- requirements
Module: not_word

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 a  input  WIDTH  operand word.
REQ-005 en  input  1  capture enable for registered outputs.
REQ-006 not_a  output  WIDTH  combinational bitwise inverse of a.
REQ-007 not_a_q  output  WIDTH  registered bitwise inverse of a, captured when en=1.
REQ-008 valid_q  output  1  high for the cycle after a capture.
REQ-009 zero_q  output  1  registered flag: captured inverse equals all zeros.

Function
REQ-010 not_a SHALL equal ~a bit-for-bit: not_a[i] = !a[i] for every i in 0..WIDTH-1.
REQ-011 not_a SHALL be purely combinational, zero-cycle latency, settled within 1 ns of any change on a.
REQ-012 not_a SHALL be independent of clk, rst_n and en, including while rst_n=0.
REQ-013 Rising clk with rst_n=1 and en=1: not_a_q SHALL load ~a, zero_q SHALL load (a == all ones), valid_q SHALL load 1.
REQ-014 Rising clk with rst_n=1 and en=0: not_a_q and zero_q SHALL hold, valid_q SHALL load 0.
REQ-015 Registered-path latency SHALL be exactly one cycle from the capturing edge.
REQ-016 No width extension or truncation: every output bit SHALL depend only on the same-index bit of a.
REQ-017 Boundaries: a=0 -> not_a = all ones, zero_q capture 0; a = all ones -> not_a = 0, zero_q capture 1.
REQ-018 Back-to-back en=1 cycles SHALL capture a new word every cycle with valid_q held high.
REQ-019 No internal state other than not_a_q, valid_q, zero_q; no X-propagation beyond the inverting logic.

Reset
REQ-020 Rising clk with rst_n=0 SHALL set not_a_q=0, valid_q=0, zero_q=0, overriding en.
REQ-021 Reset asserted mid-stream SHALL discard the capture on that edge; first capture after release occurs on the first edge with rst_n=1 and en=1.
REQ-022 Before the first clock edge registered outputs are undefined; not_a remains valid regardless.

Verification
REQ-023 Random sweep: 1024 random 32-bit values on a, check not_a == ~a after 1 ns each, no clock required -> zero mismatches.
REQ-024 a=32'h00000000 -> not_a=32'hFFFFFFFF; a=32'hFFFFFFFF -> not_a=32'h00000000; a=32'hA5A5A5A5 -> not_a=32'h5A5A5A5A.
REQ-025 rst_n=0 one edge, then rst_n=1, en=1, a=32'h0000FFFF -> next cycle not_a_q=32'hFFFF0000, valid_q=1, zero_q=0.
REQ-026 Capture a=32'hFFFFFFFF with en=1, then en=0 and a=32'h12345678 -> not_a_q stays 0, zero_q stays 1, valid_q drops to 0, not_a=32'hEDCBA987.
REQ-027 Capture a=32'h1 with en=1 and rst_n=0 on same edge -> not_a_q=0, valid_q=0, zero_q=0; not_a=32'hFFFFFFFE throughout.
